// File: rtl/tube_pkg.sv
// Shared types and constants for the tube display scheduler.
package tube_pkg;

  localparam int DIS_W   = 14;
  localparam int DIS_MAX = 9999;

  typedef logic [DIS_W-1:0] dis_t;
  typedef logic [1:0]       src_t;

  localparam src_t SRC_LIVE = 2'd0;
  localparam src_t SRC_SET  = 2'd1;
  localparam src_t SRC_ERR  = 2'd2;

  typedef enum logic [1:0] {LIVE, SET, ERR} state_t;

  function automatic dis_t clamp(input dis_t v, input dis_t lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond prescaler; tick is high for the terminal-count cycle.
module ms_tick_gen #(
  parameter int CLK_PER_MS = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LAST = cnt_t'(CLK_PER_MS - 1);

  cnt_t cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + cnt_t'(1);
  end

endmodule

// File: rtl/tube_disp_ctrl.sv
// Chooses what the 4-digit tube shows: rate-limited live distance, a held
// threshold setting, or a held error code.
module tube_disp_ctrl
  import tube_pkg::*;
#(
  parameter int CLK_PER_MS  = 100000,
  parameter int UPD_MS      = 250,
  parameter int SET_HOLD_MS = 2000,
  parameter int ERR_HOLD_MS = 1000,
  parameter int MAX_MM      = 4000,
  parameter int ERR_CODE    = 9999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             meas_valid,
  input  logic [DIS_W-1:0] meas_data,
  input  logic             meas_err,
  input  logic             set_valid,
  input  logic [DIS_W-1:0] set_data,
  output logic [DIS_W-1:0] dis_data,
  output logic [1:0]       dis_src,
  output logic             upd_pulse
);

  typedef logic [15:0] tmr_t;

  localparam dis_t MAX_V    = dis_t'(MAX_MM);
  localparam dis_t LIM_V    = dis_t'(DIS_MAX);
  localparam dis_t ERR_V    = dis_t'(ERR_CODE);
  localparam tmr_t UPD_LAST = tmr_t'(UPD_MS - 1);
  localparam tmr_t SET_LAST = tmr_t'(SET_HOLD_MS - 1);
  localparam tmr_t ERR_LAST = tmr_t'(ERR_HOLD_MS - 1);

  logic   tick;
  state_t state;
  logic   pending;
  dis_t   pend_val;
  logic   upd_ok;
  tmr_t   upd_tmr;
  tmr_t   hold_tmr;
  tmr_t   hold_last;
  logic   good_meas;
  logic   bad_meas;

  ms_tick_gen #(.CLK_PER_MS(CLK_PER_MS)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign good_meas = meas_valid & ~meas_err;
  assign bad_meas  = meas_valid &  meas_err;
  assign hold_last = (state == ERR) ? ERR_LAST : SET_LAST;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LIVE;
      dis_data  <= '0;
      dis_src   <= SRC_LIVE;
      upd_pulse <= 1'b0;
      pending   <= 1'b0;
      pend_val  <= '0;
      upd_ok    <= 1'b1;
      upd_tmr   <= '0;
      hold_tmr  <= '0;
    end else begin
      upd_pulse <= 1'b0;

      // Rate-limit timer only runs while blocked, so it saturates at UPD_MS.
      if (tick && !upd_ok) begin
        upd_tmr <= upd_tmr + tmr_t'(1);
        if (upd_tmr == UPD_LAST) upd_ok <= 1'b1;
      end

      if (bad_meas) begin
        state     <= ERR;
        dis_data  <= ERR_V;
        dis_src   <= SRC_ERR;
        upd_pulse <= 1'b1;
        hold_tmr  <= '0;
      end else if (set_valid && state != ERR) begin
        state     <= SET;
        dis_data  <= clamp(set_data, LIM_V);
        dis_src   <= SRC_SET;
        upd_pulse <= 1'b1;
        hold_tmr  <= '0;
      end else if (state == LIVE) begin
        if (pending && upd_ok) begin
          dis_data  <= pend_val;
          pending   <= 1'b0;
          upd_pulse <= 1'b1;
          upd_ok    <= 1'b0;
          upd_tmr   <= '0;
        end
      end else if (tick) begin
        if (hold_tmr == hold_last) begin
          // Hold expired: a waiting live value is shown at once, bypassing upd_ok.
          state   <= LIVE;
          dis_src <= SRC_LIVE;
          if (pending) begin
            dis_data  <= pend_val;
            pending   <= 1'b0;
            upd_pulse <= 1'b1;
            upd_ok    <= 1'b0;
            upd_tmr   <= '0;
          end
        end else begin
          hold_tmr <= hold_tmr + tmr_t'(1);
        end
      end

      if (good_meas) begin
        pend_val <= clamp(meas_data, MAX_V);
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tube_disp_ctrl.sv
// Directed bench for tube_disp_ctrl: cycle-vector table plus hold/reset sequences.
module tb_tube_disp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        meas_valid;
  logic [13:0] meas_data;
  logic        meas_err;
  logic        set_valid;
  logic [13:0] set_data;
  logic [13:0] dis_data;
  logic [1:0]  dis_src;
  logic        upd_pulse;

  int checks   = 0;
  int failures = 0;

  tube_disp_ctrl #(
    .CLK_PER_MS  (10),
    .UPD_MS      (4),
    .SET_HOLD_MS (20),
    .ERR_HOLD_MS (10),
    .MAX_MM      (4000),
    .ERR_CODE    (9999)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .meas_valid (meas_valid),
    .meas_data  (meas_data),
    .meas_err   (meas_err),
    .set_valid  (set_valid),
    .set_data   (set_data),
    .dis_data   (dis_data),
    .dis_src    (dis_src),
    .upd_pulse  (upd_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mv;
    logic [13:0] md;
    logic        me;
    logic        sv;
    logic [13:0] sd;
    int          ncyc;
    int          ed;
    int          es;
    int          ep;
  } vec_t;

  vec_t tv[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic clear_in();
    meas_valid = 1'b0;
    meas_err   = 1'b0;
    set_valid  = 1'b0;
  endtask

  task automatic wait_src_leave(input logic [1:0] from, input int maxc, inout int n);
    while (dis_src == from && n < maxc) begin
      step();
      n++;
    end
  endtask

  task automatic chk_out(input string name, input int d, input int s, input int p);
    chk({name, ".data"},  int'(dis_data),  d);
    chk({name, ".src"},   int'(dis_src),   s);
    chk({name, ".pulse"}, int'(upd_pulse), p);
  endtask

  initial begin
    int n;

    // Ticks land on edges 10,20,30.. counted from the last reset edge.
    tv[0]  = '{1'b0, 14'd0,    1'b0, 1'b0, 14'd0, 1,  0,    0, 0};
    tv[1]  = '{1'b1, 14'd1234, 1'b0, 1'b0, 14'd0, 1,  0,    0, 0};
    tv[2]  = '{1'b0, 14'd0,    1'b0, 1'b0, 14'd0, 1,  1234, 0, 1};
    tv[3]  = '{1'b0, 14'd0,    1'b0, 1'b0, 14'd0, 1,  1234, 0, 0};
    tv[4]  = '{1'b0, 14'd0,    1'b0, 1'b0, 14'd0, 36, 1234, 0, 0};
    tv[5]  = '{1'b1, 14'd1000, 1'b0, 1'b0, 14'd0, 1,  1234, 0, 0};
    tv[6]  = '{1'b0, 14'd0,    1'b0, 1'b0, 14'd0, 1,  1000, 0, 1};
    tv[7]  = '{1'b0, 14'd0,    1'b0, 1'b0, 14'd0, 1,  1000, 0, 0};
    tv[8]  = '{1'b1, 14'd1100, 1'b0, 1'b0, 14'd0, 1,  1000, 0, 0};
    tv[9]  = '{1'b0, 14'd0,    1'b0, 1'b0, 14'd0, 5,  1000, 0, 0};
    tv[10] = '{1'b1, 14'd1200, 1'b0, 1'b0, 14'd0, 1,  1000, 0, 0};
    tv[11] = '{1'b0, 14'd0,    1'b0, 1'b0, 14'd0, 30, 1000, 0, 0};
    tv[12] = '{1'b0, 14'd0,    1'b0, 1'b0, 14'd0, 1,  1200, 0, 1};
    tv[13] = '{1'b1, 14'd5000, 1'b0, 1'b0, 14'd0, 1,  1200, 0, 0};
    tv[14] = '{1'b0, 14'd0,    1'b0, 1'b0, 14'd0, 38, 1200, 0, 0};
    tv[15] = '{1'b0, 14'd0,    1'b0, 1'b0, 14'd0, 1,  4000, 0, 1};

    rst_n = 1'b0;
    meas_data = '0;
    set_data  = '0;
    clear_in();
    repeat (3) step();
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      meas_valid = tv[i].mv;
      meas_data  = tv[i].md;
      meas_err   = tv[i].me;
      set_valid  = tv[i].sv;
      set_data   = tv[i].sd;
      step();
      clear_in();
      for (int k = 1; k < tv[i].ncyc; k++) step();
      chk_out($sformatf("vec%0d", i), tv[i].ed, tv[i].es, tv[i].ep);
    end

    // Set and good measurement together: setting shown, measurement waits.
    set_valid = 1'b1; set_data = 14'd300;
    meas_valid = 1'b1; meas_data = 14'd800;
    step(); clear_in();
    chk_out("set_vs_meas", 300, 1, 1);
    n = 0;
    wait_src_leave(2'd1, 260, n);
    chk_range("set_hold_len", n, 191, 200);
    chk_out("set_return", 800, 0, 1);

    // Re-set at 15 ms extends the hold; no pending value so setting stays shown.
    step();
    set_valid = 1'b1; set_data = 14'd500;
    step(); clear_in();
    repeat (150) step();
    chk("set_before_reload.src", int'(dis_src), 1);
    set_valid = 1'b1; set_data = 14'd600;
    step(); clear_in();
    chk_out("set_reload", 600, 1, 1);
    repeat (55) step();
    chk("set_extended.src", int'(dis_src), 1);
    n = 55;
    wait_src_leave(2'd1, 260, n);
    chk_range("set_reload_hold_len", n, 191, 200);
    chk_out("set_return_nopend", 600, 0, 0);

    // Clamp of an oversized setting.
    set_valid = 1'b1; set_data = 14'd12000;
    step(); clear_in();
    chk_out("set_clamp", 9999, 1, 1);
    repeat (3) step();

    // Error during SET, good measurement captured, set ignored in ERR.
    meas_valid = 1'b1; meas_err = 1'b1; meas_data = 14'd77;
    step(); clear_in();
    chk_out("err_enter", 9999, 2, 1);
    meas_valid = 1'b1; meas_data = 14'd850;
    step(); clear_in();
    set_valid = 1'b1; set_data = 14'd111;
    step(); clear_in();
    chk_out("err_ignores_set", 9999, 2, 0);
    n = 2;
    wait_src_leave(2'd2, 150, n);
    chk_range("err_hold_len", n, 91, 100);
    chk_out("err_return", 850, 0, 1);

    // Error beats set on the same cycle.
    repeat (2) step();
    set_valid = 1'b1; set_data = 14'd222;
    meas_valid = 1'b1; meas_err = 1'b1;
    step(); clear_in();
    chk_out("err_over_set", 9999, 2, 1);
    repeat (20) step();

    // Reset mid-hold, then a fresh measurement shows with 2-clk latency.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_out("rst_mid_err", 0, 0, 0);
    meas_valid = 1'b1; meas_data = 14'd2222;
    step(); clear_in();
    chk_out("post_rst_lat1", 0, 0, 0);
    step();
    chk_out("post_rst_lat2", 2222, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
